array_access_arbiter: RTL and testbench
=======================================

Name: array_access_arbiter

Overview:
- Shares the single-port 2048-word array primitive between three requesters: AXI-lite read (ar/r streams), AXI-lite write (aw/w/b streams) and the compute-function port (c_*).
- Serialises accesses with round-robin grant, sequences the array's 1-cycle synchronous read, and drives each requester's response handshake.
- Sits between the AXI-lite top-level stream adapters and the array instance. One access is in flight at a time.

Parameters:
- AN, 11, address width in words (byte address already shifted right by 2 upstream).
- DN, 32, data width.
- N, 2048, array depth. Addresses >= N are an error: no access occurs, and a read returns 0.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- ar  in  AN  read address; ar_valid in 1; ar_ready out 1
- r  out  DN  read data; r_valid out 1; r_ready in 1
- aw  in  AN  write address; aw_valid in 1; aw_ready out 1
- w  in  DN  write data; w_valid in 1; w_ready out 1
- b_valid  out  1  write response (null stream); b_ready in 1
- c_addr  in  AN  compute address; c_we in 1; c_wdata in DN; c_valid in 1; c_ready out 1
- c_rdata  out  DN  compute response data; c_rvalid out 1; c_rready in 1
- arr_addr  out  AN  array address
- arr_we  out  1  array write enable
- arr_di  out  DN  array write data
- arr_do  in  DN  array read data, valid the cycle after arr_addr is presented with arr_we=0

Behaviour:
- Reset values: all *_ready=0, r_valid=0, b_valid=0, c_rvalid=0, arr_we=0, arr_addr=0, arr_di=0, r=0, c_rdata=0, state=IDLE, rr_ptr=0.
- Requester eligibility in IDLE:
  - R is eligible when ar_valid=1.
  - W is eligible only when aw_valid=1 and w_valid=1 together. A lone aw or w is never consumed.
  - C is eligible when c_valid=1.
- Grant: round-robin R -> W -> C, starting after rr_ptr. rr_ptr advances to the granted requester.
- Acceptance: in the grant cycle the granted ready(s) are pulsed high combinationally for exactly one cycle. For W, aw_ready and w_ready assert together. All other readies stay 0.
- IDLE -> RD (R, or C with c_we=0):
  - Drive arr_addr and arr_we=0.
  - Next cycle, capture arr_do into r or c_rdata, then go to RRESP.
- IDLE -> WR (W, or C with c_we=1):
  - Drive arr_addr, arr_di and arr_we=1 for exactly one cycle, then go to WRESP.
- RRESP: hold r_valid=1 (or c_rvalid=1) and data stable until the matching ready=1, then return to IDLE.
- WRESP: hold b_valid=1 (or c_rvalid=1 with c_rdata=written value) until ready, then return to IDLE.
- Latency:
  - Read: grant cycle N, valid asserted at cycle N+2.
  - Write: array written at cycle N, response valid at cycle N+1.
  - Minimum 3 cycles per read and 2 per write when ready is held high.
- Out-of-range address (addr >= N): arr_we is forced to 0. A read returns 0. The response handshake still completes, so the bus never hangs.
- Simultaneous requests: only one grant per IDLE cycle. Losers keep valid high and are served in round-robin order. No starvation: every requester is served within 3 transactions.
- Read-after-write from different requesters: the write completes in the array before any later-granted read samples it. A read granted after a write returns the new value.
- Response backpressure: the arbiter does not return to IDLE, and so accepts nothing new, until the pending response handshake completes.
- Reset mid-operation: immediate return to reset values. A pending write not yet strobed is dropped. A write already strobed persists in the array. Pending responses are discarded.
- arr_we is never high in two consecutive cycles and never high outside WR.

Test Plan:
- Single AXI write then read: aw=5, w=0xDEADBEEF, b_ready=1 -> arr_we one cycle at addr 5, b_valid the next cycle. Then ar=5 -> r=0xDEADBEEF with r_valid 2 cycles after ar_ready.
- Split write channels: aw_valid=1 for 4 cycles before w_valid -> no aw_ready and no arr_we until w_valid is high. Both readies then pulse in the same cycle.
- Three-way contention: R, W and C valid simultaneously and held, rr_ptr=0 -> grant order W, C, R. Repeat with all three held -> W, C, R again; each is served once per 3 grants.
- Backpressure: r_ready=0 for 10 cycles after a read of addr 7 holding 0x1234 -> r_valid and r stay stable, no other grant, and c_valid stays unacknowledged. r_ready=1 -> C is granted the next cycle.
- Out-of-range and compute path: C write addr 2047 = 0xA5 then read -> 0xA5. C write addr 2048 (AN=12 build, N=2048) -> arr_we stays 0 and a c_rvalid handshake completes. A read of 2048 returns 0.
- Reset during RRESP (r_valid=1) -> next cycle r_valid=0 and state=IDLE. A previously completed write to addr 3 still reads back correctly after reset release.

Source files
------------

// File: rtl/array_access_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous array between the
// AXI-lite read port, the AXI-lite write port and the compute port.
// One access is in flight at a time. The array address, write strobe and
// write data are driven in the grant cycle itself. A write therefore lands
// in the array in its grant cycle, and a read sees its data two cycles later.
module array_access_arbiter #(
  parameter int unsigned AN = 11,
  parameter int unsigned DN = 32,
  parameter int unsigned N  = 2048
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AN-1:0] ar,
  input  logic          ar_valid,
  output logic          ar_ready,
  output logic [DN-1:0] r,
  output logic          r_valid,
  input  logic          r_ready,
  input  logic [AN-1:0] aw,
  input  logic          aw_valid,
  output logic          aw_ready,
  input  logic [DN-1:0] w,
  input  logic          w_valid,
  output logic          w_ready,
  output logic          b_valid,
  input  logic          b_ready,
  input  logic [AN-1:0] c_addr,
  input  logic          c_we,
  input  logic [DN-1:0] c_wdata,
  input  logic          c_valid,
  output logic          c_ready,
  output logic [DN-1:0] c_rdata,
  output logic          c_rvalid,
  input  logic          c_rready,
  output logic [AN-1:0] arr_addr,
  output logic          arr_we,
  output logic [DN-1:0] arr_di,
  input  logic [DN-1:0] arr_do
);

  typedef enum logic [1:0] {IDLE, RD, RRESP, WRESP} state_t;

  localparam logic [1:0] SRC_R = 2'd0;
  localparam logic [1:0] SRC_W = 2'd1;
  localparam logic [1:0] SRC_C = 2'd2;

  state_t        state;
  logic [1:0]    rr_ptr;
  logic [1:0]    owner;
  logic          oor;
  logic [2:0]    elig;
  logic [1:0]    cand1;
  logic [1:0]    cand2;
  logic          gnt;
  logic [1:0]    gnt_src;
  logic [AN-1:0] gnt_addr;
  logic          gnt_we;
  logic [DN-1:0] gnt_wdata;
  logic          gnt_in_range;
  logic          resp_ready;

  function automatic logic [1:0] next_src(input logic [1:0] s);
    return (s == SRC_C) ? SRC_R : s + 2'd1;
  endfunction

  // Eligibility and round-robin pick, starting just after the last winner
  always_comb begin
    elig    = {c_valid, aw_valid & w_valid, ar_valid};
    cand1   = next_src(rr_ptr);
    cand2   = next_src(cand1);
    gnt     = 1'b0;
    gnt_src = rr_ptr;
    if (state == IDLE && !rst) begin
      if (elig[cand1]) begin
        gnt     = 1'b1;
        gnt_src = cand1;
      end else if (elig[cand2]) begin
        gnt     = 1'b1;
        gnt_src = cand2;
      end else if (elig[rr_ptr]) begin
        gnt     = 1'b1;
        gnt_src = rr_ptr;
      end
    end
  end

  // Access parameters of the requester being granted
  always_comb begin
    gnt_addr  = ar;
    gnt_we    = 1'b0;
    gnt_wdata = '0;
    case (gnt_src)
      SRC_W: begin
        gnt_addr  = aw;
        gnt_we    = 1'b1;
        gnt_wdata = w;
      end
      SRC_C: begin
        gnt_addr  = c_addr;
        gnt_we    = c_we;
        gnt_wdata = c_wdata;
      end
      default: ;
    endcase
    gnt_in_range = 32'(gnt_addr) < N;
  end

  // Grant-cycle acceptance pulses and array drive; writes out of range are suppressed
  always_comb begin
    ar_ready = gnt && (gnt_src == SRC_R);
    aw_ready = gnt && (gnt_src == SRC_W);
    w_ready  = aw_ready;
    c_ready  = gnt && (gnt_src == SRC_C);
    arr_addr = gnt ? gnt_addr : '0;
    arr_we   = gnt && gnt_we && gnt_in_range;
    arr_di   = (gnt && gnt_we) ? gnt_wdata : '0;
  end

  // Ready of the response channel belonging to the access in flight
  always_comb begin
    case (owner)
      SRC_R:   resp_ready = r_ready;
      SRC_W:   resp_ready = b_ready;
      default: resp_ready = c_rready;
    endcase
  end

  // Access sequencing, read capture and response handshakes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= SRC_R;
      owner    <= SRC_R;
      oor      <= 1'b0;
      r        <= '0;
      r_valid  <= 1'b0;
      b_valid  <= 1'b0;
      c_rdata  <= '0;
      c_rvalid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt) begin
            rr_ptr <= gnt_src;
            owner  <= gnt_src;
            oor    <= !gnt_in_range;
            if (gnt_we) begin
              state <= WRESP;
              if (gnt_src == SRC_C) begin
                c_rvalid <= 1'b1;
                c_rdata  <= gnt_wdata;
              end else begin
                b_valid <= 1'b1;
              end
            end else begin
              state <= RD;
            end
          end
        end
        RD: begin
          state <= RRESP;
          if (owner == SRC_C) begin
            c_rdata  <= oor ? '0 : arr_do;
            c_rvalid <= 1'b1;
          end else begin
            r       <= oor ? '0 : arr_do;
            r_valid <= 1'b1;
          end
        end
        RRESP, WRESP: begin
          if (resp_ready) begin
            state    <= IDLE;
            r_valid  <= 1'b0;
            b_valid  <= 1'b0;
            c_rvalid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_array_access_arbiter.sv
// Bench for array_access_arbiter: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// transaction-level model (round-robin order, shadow memory, response times).
module tb_array_access_arbiter;

  localparam int unsigned AN = 12;
  localparam int unsigned DN = 32;
  localparam int unsigned N  = 2048;

  logic          clk = 1'b0;
  logic          rst;
  logic [AN-1:0] ar;
  logic          ar_valid;
  logic          ar_ready;
  logic [DN-1:0] r;
  logic          r_valid;
  logic          r_ready;
  logic [AN-1:0] aw;
  logic          aw_valid;
  logic          aw_ready;
  logic [DN-1:0] w;
  logic          w_valid;
  logic          w_ready;
  logic          b_valid;
  logic          b_ready;
  logic [AN-1:0] c_addr;
  logic          c_we;
  logic [DN-1:0] c_wdata;
  logic          c_valid;
  logic          c_ready;
  logic [DN-1:0] c_rdata;
  logic          c_rvalid;
  logic          c_rready;
  logic [AN-1:0] arr_addr;
  logic          arr_we;
  logic [DN-1:0] arr_di;
  logic [DN-1:0] arr_do;

  bit   [DN-1:0] mem     [N];
  bit   [DN-1:0] ref_mem [N];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            order [$];
  int            exp_order [6] = '{1, 2, 0, 1, 2, 0};

  array_access_arbiter #(.AN(AN), .DN(DN), .N(N)) dut (
    .clk(clk), .rst(rst),
    .ar(ar), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r(r), .r_valid(r_valid), .r_ready(r_ready),
    .aw(aw), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w(w), .w_valid(w_valid), .w_ready(w_ready),
    .b_valid(b_valid), .b_ready(b_ready),
    .c_addr(c_addr), .c_we(c_we), .c_wdata(c_wdata), .c_valid(c_valid),
    .c_ready(c_ready), .c_rdata(c_rdata), .c_rvalid(c_rvalid), .c_rready(c_rready),
    .arr_addr(arr_addr), .arr_we(arr_we), .arr_di(arr_di), .arr_do(arr_do)
  );

  always #5 clk = ~clk;

  // Single-port synchronous array; out-of-range reads return junk on purpose
  always @(posedge clk) begin
    if (arr_we && 32'(arr_addr) < N) mem[arr_addr[10:0]] <= arr_di;
    arr_do <= (32'(arr_addr) < N) ? mem[arr_addr[10:0]] : 32'hBAD0_BAD0;
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic bit eligible(input int s);
    case (s)
      0:       return ar_valid;
      1:       return aw_valid && w_valid;
      default: return c_valid;
    endcase
  endfunction

  // Reference model: who wins, what the array sees, when and what each response carries
  initial begin : model
    int cyc, who, last, vat, g;
    bit busy, gw, vis, rrdy;
    logic [DN-1:0] dat, gd;
    logic [AN-1:0] ga;
    cyc = 0; who = 0; last = 0; vat = 0; busy = 1'b0; dat = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        chk("rst_ready", 64'({ar_ready, aw_ready, w_ready, c_ready}), 64'(0));
        chk("rst_valid", 64'({r_valid, b_valid, c_rvalid}), 64'(0));
        chk("rst_arr", 64'({arr_we, arr_addr, arr_di}), 64'(0));
        chk("rst_data", 64'({r, c_rdata}), 64'(0));
        busy = 1'b0;
        last = 0;
      end else begin
        g = -1;
        if (!busy)
          for (int k = 1; k <= 3; k++)
            if (g < 0 && eligible((last + k) % 3)) g = (last + k) % 3;
        ga = '0; gd = '0; gw = 1'b0;
        case (g)
          0: ga = ar;
          1: begin ga = aw; gd = w; gw = 1'b1; end
          2: begin ga = c_addr; gd = c_wdata; gw = c_we; end
          default: ;
        endcase
        chk("ready", 64'({ar_ready, aw_ready, w_ready, c_ready}),
            64'({g == 0, g == 1, g == 1, g == 2}));
        chk("arr_we", 64'(arr_we), 64'(g >= 0 && gw && 32'(ga) < N));
        if (g >= 0) chk("arr_addr", 64'(arr_addr), 64'(ga));
        if (g >= 0 && gw) chk("arr_di", 64'(arr_di), 64'(gd));
        vis = busy && cyc >= vat;
        chk("resp_valid", 64'({r_valid, b_valid, c_rvalid}),
            64'({vis && who == 0, vis && who == 1, vis && who == 2}));
        if (vis && who == 0) chk("r", 64'(r), 64'(dat));
        if (vis && who == 2) chk("c_rdata", 64'(c_rdata), 64'(dat));
        rrdy = (who == 0) ? r_ready : (who == 1) ? b_ready : c_rready;
        if (g >= 0) begin
          busy = 1'b1; who = g; last = g;
          if (gw) begin
            if (32'(ga) < N) ref_mem[ga[10:0]] = gd;
            dat = gd;
            vat = cyc + 1;
          end else begin
            dat = (32'(ga) < N) ? ref_mem[ga[10:0]] : '0;
            vat = cyc + 2;
          end
        end else if (vis && rrdy) begin
          busy = 1'b0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_valids();
    ar_valid = 1'b0; aw_valid = 1'b0; w_valid = 1'b0; c_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    clear_valids();
    repeat (n) step();
  endtask

  function automatic logic [AN-1:0] rnd_addr();
    if ($urandom_range(0, 7) == 0)
      case ($urandom_range(0, 3))
        0:       return 12'd2046;
        1:       return 12'd2047;
        2:       return 12'd2048;
        default: return 12'd4095;
      endcase
    return 12'($urandom_range(0, 15));
  endfunction

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: bench did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "timeout");
  end

  initial begin : stim
    bit a_r, a_w, a_c;
    rst = 1'b1;
    ar = '0; aw = '0; w = '0; c_addr = '0; c_we = 1'b0; c_wdata = '0;
    clear_valids();
    r_ready = 1'b1; b_ready = 1'b1; c_rready = 1'b1;
    @(negedge clk);
    chk("reset_outputs", 64'({ar_ready, aw_ready, w_ready, c_ready, r_valid, b_valid, c_rvalid, arr_we}), 64'(0));
    step(); step();
    rst = 1'b0;
    idle(2);

    // Single AXI write then read of address 5
    aw = 12'd5; aw_valid = 1'b1; w = 32'hDEAD_BEEF; w_valid = 1'b1;
    @(negedge clk);
    chk("wr_ready", 64'({aw_ready, w_ready}), 64'(2'b11));
    chk("wr_strobe", 64'({arr_we, arr_addr, arr_di}), 64'({1'b1, 12'd5, 32'hDEAD_BEEF}));
    step(); clear_valids();
    @(negedge clk);
    chk("wr_bvalid", 64'({b_valid, arr_we}), 64'(2'b10));
    step(); ar = 12'd5; ar_valid = 1'b1;
    @(negedge clk);
    chk("rd_accept", 64'(ar_ready), 64'(1));
    step(); ar_valid = 1'b0;
    @(negedge clk);
    chk("rd_wait", 64'(r_valid), 64'(0));
    step();
    @(negedge clk);
    chk("rd_data", 64'({r_valid, r}), 64'({1'b1, 32'hDEAD_BEEF}));
    idle(2);

    // Split write channels: lone aw is never consumed
    aw = 12'd6; aw_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("split_hold", 64'({aw_ready, w_ready, arr_we}), 64'(0));
      step();
    end
    w = 32'h0BAD_F00D; w_valid = 1'b1;
    @(negedge clk);
    chk("split_accept", 64'({aw_ready, w_ready, arr_we}), 64'(3'b111));
    step();
    idle(3);

    // Three-way contention from reset pointer: W, C, R, W, C, R
    rst = 1'b1; step(); rst = 1'b0;
    ar = 12'd20; ar_valid = 1'b1;
    aw = 12'd10; w = 32'h77; aw_valid = 1'b1; w_valid = 1'b1;
    c_addr = 12'd30; c_we = 1'b0; c_valid = 1'b1;
    for (int i = 0; i < 40 && order.size() < 6; i++) begin
      @(negedge clk);
      if (aw_ready) order.push_back(1);
      if (c_ready)  order.push_back(2);
      if (ar_ready) order.push_back(0);
      step();
    end
    for (int i = 0; i < 6; i++)
      chk("rr_order", 64'((i < order.size()) ? order[i] : 9), 64'(exp_order[i]));
    idle(4);

    // Backpressure on a read holding 0x1234
    aw = 12'd7; w = 32'h1234; aw_valid = 1'b1; w_valid = 1'b1;
    step();
    idle(2);
    r_ready = 1'b0; ar = 12'd7; ar_valid = 1'b1;
    @(negedge clk);
    chk("bp_accept", 64'(ar_ready), 64'(1));
    step(); ar_valid = 1'b0; c_addr = 12'd1; c_we = 1'b0; c_valid = 1'b1;
    @(negedge clk);
    chk("bp_rd", 64'({r_valid, c_ready}), 64'(0));
    for (int i = 0; i < 10; i++) begin
      step();
      @(negedge clk);
      chk("bp_hold", 64'({r_valid, c_ready, r}), 64'({1'b1, 1'b0, 32'h1234}));
    end
    step(); r_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", 64'({r_valid, c_ready}), 64'(2'b10));
    step();
    @(negedge clk);
    chk("bp_next_grant", 64'(c_ready), 64'(1));
    step();
    idle(4);

    // Compute path at the top address and just past the end
    c_addr = 12'd2047; c_we = 1'b1; c_wdata = 32'hA5; c_valid = 1'b1;
    @(negedge clk);
    chk("c_wr_strobe", 64'({c_ready, arr_we}), 64'(2'b11));
    step(); c_valid = 1'b0;
    @(negedge clk);
    chk("c_wr_resp", 64'({c_rvalid, c_rdata}), 64'({1'b1, 32'hA5}));
    step(); c_we = 1'b0; c_valid = 1'b1;
    @(negedge clk);
    chk("c_rd_accept", 64'(c_ready), 64'(1));
    step(); c_valid = 1'b0;
    @(negedge clk);
    chk("c_rd_wait", 64'(c_rvalid), 64'(0));
    step();
    @(negedge clk);
    chk("c_rd_data", 64'({c_rvalid, c_rdata}), 64'({1'b1, 32'hA5}));
    step(); c_addr = 12'd2048; c_we = 1'b1; c_wdata = 32'h5A; c_valid = 1'b1;
    @(negedge clk);
    chk("oor_no_strobe", 64'({c_ready, arr_we}), 64'(2'b10));
    step(); c_valid = 1'b0;
    @(negedge clk);
    chk("oor_resp", 64'(c_rvalid), 64'(1));
    step(); ar = 12'd2048; ar_valid = 1'b1;
    @(negedge clk);
    chk("oor_rd_accept", 64'(ar_ready), 64'(1));
    step(); ar_valid = 1'b0;
    step();
    @(negedge clk);
    chk("oor_rd_zero", 64'({r_valid, r}), 64'({1'b1, 32'h0}));
    idle(3);

    // Reset while a read response is pending; earlier write survives
    aw = 12'd3; w = 32'h33; aw_valid = 1'b1; w_valid = 1'b1;
    step();
    idle(2);
    r_ready = 1'b0; ar = 12'd9; ar_valid = 1'b1;
    step(); ar_valid = 1'b0;
    step();
    @(negedge clk);
    chk("rrst_pending", 64'(r_valid), 64'(1));
    step(); rst = 1'b1;
    @(negedge clk);
    chk("rrst_cleared", 64'({r_valid, b_valid, c_rvalid, ar_ready}), 64'(0));
    step(); rst = 1'b0; r_ready = 1'b1; ar = 12'd3; ar_valid = 1'b1;
    @(negedge clk);
    chk("rrst_accept", 64'(ar_ready), 64'(1));
    step(); ar_valid = 1'b0;
    step();
    @(negedge clk);
    chk("rrst_readback", 64'({r_valid, r}), 64'({1'b1, 32'h33}));
    idle(2);

    // Randomized traffic; valids held until accepted, occasional resets
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      a_r = ar_ready; a_w = aw_ready; a_c = c_ready;
      step();
      rst = ($urandom_range(0, 299) == 0);
      if (!ar_valid || a_r) begin
        ar_valid = ($urandom_range(0, 2) == 0);
        ar = rnd_addr();
      end
      if (!aw_valid || a_w) begin
        aw_valid = ($urandom_range(0, 2) == 0);
        aw = rnd_addr();
      end
      if (!w_valid || a_w) begin
        w_valid = ($urandom_range(0, 2) == 0);
        w = $urandom;
      end
      if (!c_valid || a_c) begin
        c_valid = ($urandom_range(0, 2) == 0);
        c_addr = rnd_addr();
        c_we = $urandom_range(0, 1) == 1;
        c_wdata = $urandom;
      end
      r_ready  = ($urandom_range(0, 3) != 0);
      b_ready  = ($urandom_range(0, 3) != 0);
      c_rready = ($urandom_range(0, 3) != 0);
    end
    rst = 1'b0;
    r_ready = 1'b1; b_ready = 1'b1; c_rready = 1'b1;
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
